// File: rtl/censor_word_filter.sv
// Byte-stream word filter. Letters of each word are buffered while an external
// pearson8 hasher digests them; at the end of the word the hash is looked up in a
// small banned-hash dictionary and the word is replayed verbatim or censored.
module censor_word_filter #(
    parameter int unsigned MAX_WORD    = 32,
    parameter int unsigned DICT_DEPTH  = 16,
    parameter logic [7:0]  CENSOR_CHAR = 8'h2A
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [7:0]                    s_data,
    input  logic                          s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [7:0]                    m_data,
    output logic                          m_last,
    output logic                          hash_enable,
    output logic                          hash_init,
    output logic [7:0]                    hash_char,
    input  logic [7:0]                    hash_in,
    input  logic                          dict_we,
    input  logic [$clog2(DICT_DEPTH)-1:0] dict_addr,
    input  logic [7:0]                    dict_hash,
    input  logic                          dict_en
);

    localparam int unsigned      LEN_W   = $clog2(MAX_WORD + 1);
    localparam int unsigned      IDX_W   = (MAX_WORD > 1) ? $clog2(MAX_WORD) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORD);

    typedef enum logic [1:0] {
        StCollect,
        StCheck,
        StEmit
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_pend_q, last_pend_d;
    logic             match_q, match_d;

    logic [7:0]            word_buf [MAX_WORD];
    logic                  buf_we;
    logic [DICT_DEPTH-1:0] dict_valid_q;
    logic [7:0]            dict_val_q [DICT_DEPTH];
    logic                  dict_hit;

    logic       can_load;
    logic       load;
    logic [7:0] load_data;
    logic       load_last;
    logic       is_letter;
    logic       last_byte;

    assign can_load  = !m_valid || m_ready;
    assign is_letter = ((s_data >= 8'h41) && (s_data <= 8'h5A)) ||
                       ((s_data >= 8'h61) && (s_data <= 8'h7A));
    assign last_byte = (LEN_W'(idx_q) + LEN_W'(1)) == len_q;

    // Compare the finished hash against every valid dictionary entry.
    always_comb begin
        dict_hit = 1'b0;
        for (int unsigned i = 0; i < DICT_DEPTH; i++) begin
            if (dict_valid_q[i] && (dict_val_q[i] == hash_in)) begin
                dict_hit = 1'b1;
            end
        end
    end

    // Next-state, handshake, hasher control and output-register load selection.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        last_pend_d = last_pend_q;
        match_d     = match_q;
        s_ready     = 1'b0;
        buf_we      = 1'b0;
        load        = 1'b0;
        load_data   = 8'h00;
        load_last   = 1'b0;
        hash_enable = 1'b0;
        hash_init   = 1'b0;
        hash_char   = 8'h00;
        unique case (state_q)
            StCollect: begin
                if (len_q == MAX_LEN) begin
                    // Buffer full: split here, the pending byte waits for the next word.
                    state_d = StCheck;
                end else if (is_letter) begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        buf_we      = 1'b1;
                        len_d       = len_q + LEN_W'(1);
                        hash_enable = 1'b1;
                        hash_char   = s_data | 8'h20;
                        if (s_last) begin
                            last_pend_d = 1'b1;
                            state_d     = StCheck;
                        end
                    end
                end else if (len_q == '0) begin
                    s_ready = can_load;
                    if (s_valid && can_load) begin
                        load      = 1'b1;
                        load_data = s_data;
                        load_last = s_last;
                    end
                end else if (s_valid) begin
                    // Delimiter stays pending until the word ahead of it is replayed.
                    state_d = StCheck;
                end
            end
            StCheck: begin
                match_d = dict_hit;
                idx_d   = '0;
                state_d = StEmit;
            end
            StEmit: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_data = match_q ? CENSOR_CHAR : word_buf[idx_q];
                    if (last_byte) begin
                        load_last   = last_pend_q;
                        hash_enable = 1'b1;
                        hash_init   = 1'b1;
                        len_d       = '0;
                        last_pend_d = 1'b0;
                        state_d     = StCollect;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = StCollect;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StCollect;
            len_q       <= '0;
            idx_q       <= '0;
            last_pend_q <= 1'b0;
            match_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            last_pend_q <= last_pend_d;
            match_q     <= match_d;
        end
    end

    // Word buffer; contents are meaningless once len is cleared, so no reset.
    always_ff @(posedge clock) begin
        if (buf_we) begin
            word_buf[len_q[IDX_W-1:0]] <= s_data;
        end
    end

    // Dictionary valid bits; reset invalidates every entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            dict_valid_q <= '0;
        end else if (dict_we) begin
            dict_valid_q[dict_addr] <= dict_en;
        end
    end

    // Dictionary hash values, only meaningful where the valid bit is set.
    always_ff @(posedge clock) begin
        if (dict_we) begin
            dict_val_q[dict_addr] <= dict_hash;
        end
    end

    // Registered output stage; holds its byte while the consumer stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_last  <= 1'b0;
        end else if (can_load) begin
            m_valid <= load;
            if (load) begin
                m_data <= load_data;
                m_last <= load_last;
            end
        end
    end

endmodule

// File: tb/tb_censor_word_filter.sv
// Self-checking bench for censor_word_filter with a behavioural hasher attached.
module tb_censor_word_filter;

    logic       clock = 1'b0;
    logic       reset;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_last;
    logic       hash_enable;
    logic       hash_init;
    logic [7:0] hash_char;
    logic [7:0] hash_in;
    logic       dict_we;
    logic [3:0] dict_addr;
    logic [7:0] dict_hash;
    logic       dict_en;

    int checks   = 0;
    int failures = 0;

    censor_word_filter dut (
        .clock      (clock),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .hash_enable(hash_enable),
        .hash_init  (hash_init),
        .hash_char  (hash_char),
        .hash_in    (hash_in),
        .dict_we    (dict_we),
        .dict_addr  (dict_addr),
        .dict_hash  (dict_hash),
        .dict_en    (dict_en)
    );

    always #5 clock = ~clock;

    // Stand-in hasher: an affine byte permutation as the Pearson table.
    function automatic logic [7:0] pt(input logic [7:0] x);
        logic [15:0] p;
        p = 16'(x) * 16'd167 + 16'd13;
        return p[7:0];
    endfunction

    logic [7:0] hash_q;
    always @(posedge clock) begin
        if (reset) hash_q <= 8'h00;
        else if (hash_enable) hash_q <= hash_init ? 8'h00 : pt(hash_q ^ hash_char);
    end
    assign hash_in = hash_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    logic [7:0] in_b[$];
    bit         in_l[$];
    logic [7:0] exp_d[$];
    bit         exp_l[$];
    logic [7:0] got_d[$];
    bit         got_l[$];
    logic       dm_valid[16];
    logic [7:0] dm_hash[16];
    bit         rand_mode   = 1'b0;
    bit         ready_fixed = 1'b1;
    bit         stuck       = 1'b0;
    int         init_cnt    = 0;
    bit         stall_prev  = 1'b0;
    bit         init_prev   = 1'b0;
    logic [8:0] stall_word;

    // Drives m_ready, collects output bytes, checks stall stability and hash clearing.
    always @(negedge clock) begin
        m_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
        #1;
        if (reset) begin
            stall_prev = 1'b0;
            init_prev  = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'({m_last, m_data}), 32'(stall_word));
            end
            if (init_prev) check("hash_cleared", 32'(hash_in), 32'd0);
            if (m_valid && m_ready) begin
                got_d.push_back(m_data);
                got_l.push_back(m_last);
            end
            if (hash_enable && hash_init) init_cnt++;
            init_prev  = hash_enable && hash_init;
            stall_prev = m_valid && !m_ready;
            stall_word = {m_last, m_data};
        end
    end

    function automatic bit is_letter(input logic [7:0] b);
        return (b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    function automatic logic [7:0] word_hash(input logic [7:0] w[$]);
        logic [7:0] h = 8'h00;
        foreach (w[i]) h = pt(h ^ (w[i] | 8'h20));
        return h;
    endfunction

    function automatic logic [7:0] str_hash(input string s);
        logic [7:0] w[$];
        for (int i = 0; i < s.len(); i++) w.push_back(s[i]);
        return word_hash(w);
    endfunction

    function automatic void emit_word(input logic [7:0] w[$], input bit l);
        logic [7:0] h;
        bit         hit = 1'b0;
        h = word_hash(w);
        for (int a = 0; a < 16; a++) if (dm_valid[a] && dm_hash[a] == h) hit = 1'b1;
        foreach (w[j]) begin
            exp_d.push_back(hit ? 8'h2A : w[j]);
            exp_l.push_back(l && (j == w.size() - 1));
        end
    endfunction

    // Golden model of the whole stream: words, forced splits, delimiters.
    function automatic void build_expected();
        logic [7:0] w[$];
        exp_d.delete();
        exp_l.delete();
        foreach (in_b[i]) begin
            if (is_letter(in_b[i])) begin
                w.push_back(in_b[i]);
                if (in_l[i] || w.size() == 32) begin
                    emit_word(w, in_l[i]);
                    w.delete();
                end
            end else begin
                if (w.size() > 0) begin
                    emit_word(w, 1'b0);
                    w.delete();
                end
                exp_d.push_back(in_b[i]);
                exp_l.push_back(in_l[i]);
            end
        end
    endfunction

    function automatic void set_input(input string s);
        in_b.delete();
        in_l.delete();
        for (int i = 0; i < s.len(); i++) begin
            in_b.push_back(s[i]);
            in_l.push_back(i == s.len() - 1);
        end
    endfunction

    function automatic void set_expect(input string s);
        exp_d.delete();
        exp_l.delete();
        for (int i = 0; i < s.len(); i++) begin
            exp_d.push_back(s[i]);
            exp_l.push_back(i == s.len() - 1);
        end
    endfunction

    task automatic dict_write(input int a, input logic [7:0] h, input bit en);
        @(negedge clock);
        dict_we   = 1'b1;
        dict_addr = 4'(a);
        dict_hash = h;
        dict_en   = en;
        @(negedge clock);
        dict_we     = 1'b0;
        dm_valid[a] = en;
        dm_hash[a]  = h;
    endtask

    task automatic clear_dict();
        for (int a = 0; a < 16; a++) dict_write(a, 8'h00, 1'b0);
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send_byte(input logic [7:0] b, input bit l);
        bit ok  = 1'b0;
        bit rdy;
        s_valid = 1'b1;
        s_data  = b;
        s_last  = l;
        for (int c = 0; c < 2000; c++) begin
            #2;
            rdy = s_ready;
            @(posedge clock);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        @(negedge clock);
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        if (!ok) begin
            stuck = 1'b1;
            checks++;
            failures++;
            $display("FAIL send_timeout: byte %0h never accepted", b);
        end
    endtask

    task automatic run_stream(input string name, input bit gaps);
        got_d.delete();
        got_l.delete();
        init_cnt = 0;
        stuck    = 1'b0;
        foreach (in_b[i]) begin
            if (stuck) break;
            send_byte(in_b[i], in_l[i]);
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
        end
        for (int c = 0; c < 30000 && got_d.size() < exp_d.size(); c++) @(negedge clock);
        repeat (40) @(negedge clock);
        check({name, " count"}, 32'(got_d.size()), 32'(exp_d.size()));
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            check($sformatf("%s byte%0d", name, i), 32'({got_l[i], got_d[i]}),
                  32'({exp_l[i], exp_d[i]}));
        end
    endtask

    typedef struct {
        string name;
        string ban;
        bit    ban_en;
        string ban2;
        string in_s;
        string exp_s;
        int    inits;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic       exp_v[6];
        logic [7:0] exp_c[6];
        string      vocab[6];
        string      delims;

        vecs[0] = '{"ab_cd",    "ab",  1'b1, "",  "ab cd",        "** cd",        2};
        vecs[1] = '{"AB.a",     "ab",  1'b1, "a", "AB.a",         "**.*",         2};
        vecs[2] = '{"hello",    "",    1'b0, "",  "hello, world", "hello, world", 2};
        vecs[3] = '{"dict_off", "ab",  1'b0, "",  "ab",           "ab",           1};
        vecs[4] = '{"case",     "cat", 1'b1, "",  "Cat cAT dog!", "*** *** dog!", 3};
        vecs[5] = '{"delim",    "ab",  1'b1, "",  "x ab,",        "x **,",        2};
        vecs[6] = '{"long",     "",    1'b0, "",  "abcdefghijklmnopqrstuvwxyzabcdefg",
                    "abcdefghijklmnopqrstuvwxyzabcdefg", 2};
        vecs[7] = '{"nolet",    "ab",  1'b1, "",  "1, 2.",        "1, 2.",        0};

        reset     = 1'b1;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        s_last    = 1'b0;
        dict_we   = 1'b0;
        dict_addr = 4'h0;
        dict_hash = 8'h00;
        dict_en   = 1'b0;
        for (int a = 0; a < 16; a++) begin
            dm_valid[a] = 1'b0;
            dm_hash[a]  = 8'h00;
        end
        repeat (3) @(negedge clock);
        #2;
        check("rst m_valid", 32'(m_valid), 32'd0);
        check("rst m_data", 32'(m_data), 32'd0);
        check("rst m_last", 32'(m_last), 32'd0);
        check("rst hash_enable", 32'(hash_enable), 32'd0);
        check("rst hash_init", 32'(hash_init), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #2;
        check("rst s_ready", 32'(s_ready), 32'd1);
        check("rst hash_in", 32'(hash_in), 32'd0);
        @(negedge clock);

        // Table-driven directed vectors.
        foreach (vecs[v]) begin
            clear_dict();
            if (vecs[v].ban.len() > 0) dict_write(0, str_hash(vecs[v].ban), vecs[v].ban_en);
            if (vecs[v].ban2.len() > 0) dict_write(1, str_hash(vecs[v].ban2), 1'b1);
            set_input(vecs[v].in_s);
            set_expect(vecs[v].exp_s);
            run_stream(vecs[v].name, 1'b0);
            check({vecs[v].name, " init_pulses"}, 32'(init_cnt), 32'(vecs[v].inits));
        end

        // Latency and back-to-back replay: "abc" then a delimiter, consumer always ready.
        clear_dict();
        got_d.delete();
        got_l.delete();
        send_byte("a", 1'b0);
        send_byte("b", 1'b0);
        send_byte("c", 1'b0);
        s_valid = 1'b1;
        s_data  = " ";
        s_last  = 1'b1;
        exp_v   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_c   = '{8'h00, 8'h00, "a", "b", "c", " "};
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (k == 5) begin
                s_valid = 1'b0;
                s_data  = 8'h00;
                s_last  = 1'b0;
            end
            #2;
            check($sformatf("lat valid%0d", k), 32'(m_valid), 32'(exp_v[k]));
            if (exp_v[k]) check($sformatf("lat data%0d", k), 32'(m_data), 32'(exp_c[k]));
        end
        check("lat last", 32'(m_last), 32'd1);
        repeat (4) @(negedge clock);

        // Reset while the word is stalled in replay: nothing may leak out.
        ready_fixed = 1'b0;
        repeat (2) @(negedge clock);
        dict_write(0, str_hash("ab"), 1'b0);
        got_d.delete();
        got_l.delete();
        send_byte("a", 1'b0);
        send_byte("b", 1'b0);
        s_valid = 1'b1;
        s_data  = " ";
        s_last  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            #2;
            if (m_valid) break;
        end
        check("rst_emit started", 32'(m_valid), 32'd1);
        @(negedge clock);
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = " ";
        @(negedge clock);
        reset = 1'b0;
        #2;
        check("rst_emit m_valid", 32'(m_valid), 32'd0);
        check("rst_emit hash_in", 32'(hash_in), 32'd0);
        @(negedge clock);
        #2;
        check("rst_emit s_ready", 32'(s_ready), 32'd1);
        check("rst_emit m_valid2", 32'(m_valid), 32'd0);
        check("rst_emit no_output", 32'(got_d.size()), 32'd0);
        ready_fixed = 1'b1;
        repeat (2) @(negedge clock);

        // Random traffic against the golden model.
        clear_dict();
        dict_write(3, str_hash("ab"), 1'b1);
        dict_write(7, str_hash("cat"), 1'b1);
        dict_write(15, str_hash("a"), 1'b1);
        dict_write(9, str_hash("zz"), 1'b0);
        vocab  = '{"ab", "cat", "Cat", "a", "hello", "AbC"};
        delims = " .,!-0";
        in_b.delete();
        in_l.delete();
        while (in_b.size() < 1000) begin
            int r;
            r = $urandom_range(0, 7);
            if (r < 6) begin
                for (int i = 0; i < vocab[r].len(); i++) begin
                    in_b.push_back(vocab[r][i]);
                    in_l.push_back(1'b0);
                end
            end else begin
                int n;
                n = $urandom_range(1, (r == 7) ? 40 : 5);
                for (int i = 0; i < n; i++) begin
                    in_b.push_back(8'($urandom_range(0, 25)) + ($urandom_range(0, 1) ? 8'h41 : 8'h61));
                    in_l.push_back(1'b0);
                end
            end
            if ($urandom_range(0, 9) == 0) in_l[in_l.size() - 1] = 1'b1;
            in_b.push_back(delims[$urandom_range(0, 5)]);
            in_l.push_back($urandom_range(0, 15) == 0);
        end
        while (in_b.size() > 1000) begin
            void'(in_b.pop_back());
            void'(in_l.pop_back());
        end
        in_l[999] = 1'b1;
        build_expected();
        rand_mode = 1'b1;
        run_stream("rand", 1'b1);
        rand_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
